// File: rtl/wb_commit_unit_pkg.sv
// rtl/wb_commit_unit_pkg.sv - shared CPU types and widths for the write-back/commit stage
package wb_commit_unit_pkg;

   localparam int REG_ADDR_W = 6;
   localparam int DATA_W     = 32;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } commit_state_t;

   function automatic logic [DATA_W-1:0] wb_data_sel(
      input logic              pc_to_reg,
      input logic              mem_to_reg,
      input logic [DATA_W-1:0] pc_plus1,
      input logic [DATA_W-1:0] mem_data,
      input logic [DATA_W-1:0] alu_data
   );
      if (pc_to_reg)
         return pc_plus1;
      else if (mem_to_reg)
         return mem_data;
      else
         return alu_data;
   endfunction

endpackage

// File: rtl/wb_commit_unit_if.sv
// rtl/wb_commit_unit_if.sv - EX/WB pipeline register bundle seen by the commit stage
interface wb_commit_unit_if;
   import wb_commit_unit_pkg::*;

   logic                  wb_valid;
   logic                  RegWrt;
   logic                  MemToReg;
   logic                  PCtoReg;
   logic                  Branching;
   logic                  BranchZero;
   logic                  Jump;
   logic                  JumpMem;
   logic                  N;
   logic                  Z;
   logic [DATA_W-1:0]     ALUResult;
   logic [DATA_W-1:0]     DataMemOutput;
   logic [DATA_W-1:0]     offset;
   logic [DATA_W-1:0]     pc_plus1;
   logic [REG_ADDR_W-1:0] rd;

   modport master (
      output wb_valid, RegWrt, MemToReg, PCtoReg,
      output Branching, BranchZero, Jump, JumpMem, N, Z,
      output ALUResult, DataMemOutput, offset, pc_plus1, rd
   );

   modport slave (
      input wb_valid, RegWrt, MemToReg, PCtoReg,
      input Branching, BranchZero, Jump, JumpMem, N, Z,
      input ALUResult, DataMemOutput, offset, pc_plus1, rd
   );

endinterface

// File: rtl/wb_redirect_sel.sv
// rtl/wb_redirect_sel.sv - combinational control-transfer taken/target priority logic
module wb_redirect_sel
   import wb_commit_unit_pkg::*;
(
   input  logic              branching,
   input  logic              branch_zero,
   input  logic              jump,
   input  logic              jump_mem,
   input  logic              n,
   input  logic              z,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] offset,
   output logic              taken,
   output logic [DATA_W-1:0] target
);

   always_comb begin
      taken  = 1'b0;
      target = '0;
      if (jump_mem) begin
         taken  = 1'b1;
         target = mem_data;
      end else if (jump) begin
         taken  = 1'b1;
         target = alu_result;
      end else if (branching && (branch_zero ? z : n)) begin
         taken  = 1'b1;
         target = offset;
      end
   end

endmodule

// File: rtl/wb_commit_unit.sv
// rtl/wb_commit_unit.sv - write-back select, PC redirect and post-redirect squash window
module wb_commit_unit
   import wb_commit_unit_pkg::*;
#(
   parameter int FLUSH_DEPTH = 3,
   parameter int CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   wb_commit_unit_if.slave       exwb,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic                  redirect_valid,
   output logic [DATA_W-1:0]     redirect_pc,
   output logic                  flushing,
   output logic [CNT_W-1:0]      retired_cnt,
   output logic [CNT_W-1:0]      redirect_cnt
);

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_DEPTH);

   commit_state_t     state, state_n;
   logic [3:0]        squash_cnt, squash_cnt_n;
   logic              live;
   logic              taken;
   logic [DATA_W-1:0] target;

   assign flushing = (state == FLUSH);
   assign live     = exwb.wb_valid && !flushing;

   wb_redirect_sel u_redirect_sel (
      .branching   (exwb.Branching),
      .branch_zero (exwb.BranchZero),
      .jump        (exwb.Jump),
      .jump_mem    (exwb.JumpMem),
      .n           (exwb.N),
      .z           (exwb.Z),
      .alu_result  (exwb.ALUResult),
      .mem_data    (exwb.DataMemOutput),
      .offset      (exwb.offset),
      .taken       (taken),
      .target      (target)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         squash_cnt <= '0;
      end else begin
         state      <= state_n;
         squash_cnt <= squash_cnt_n;
      end
   end

   // The window counts wall-clock cycles, so bubbles inside it still consume it.
   always_comb begin
      state_n      = state;
      squash_cnt_n = squash_cnt;
      case (state)
         RUN: begin
            if (live && taken) begin
               state_n      = FLUSH;
               squash_cnt_n = FLUSH_INIT;
            end
         end
         FLUSH: begin
            squash_cnt_n = squash_cnt - 4'd1;
            if (squash_cnt == 4'd1)
               state_n = RUN;
         end
         default: state_n = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we          <= 1'b0;
         rf_waddr       <= '0;
         rf_wdata       <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         retired_cnt    <= '0;
         redirect_cnt   <= '0;
      end else begin
         rf_we          <= live && exwb.RegWrt;
         rf_waddr       <= exwb.rd;
         rf_wdata       <= wb_data_sel(exwb.PCtoReg, exwb.MemToReg, exwb.pc_plus1,
                                       exwb.DataMemOutput, exwb.ALUResult);
         redirect_valid <= live && taken;
         redirect_pc    <= target;
         if (live)
            retired_cnt <= retired_cnt + 1'b1;
         if (live && taken)
            redirect_cnt <= redirect_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_commit_unit.sv
// tb/tb_wb_commit_unit.sv - directed self-checking bench for wb_commit_unit
module tb_wb_commit_unit;
   import wb_commit_unit_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0]     rf_wdata;
   logic                  redirect_valid;
   logic [DATA_W-1:0]     redirect_pc;
   logic                  flushing;
   logic [31:0]           retired_cnt;
   logic [31:0]           redirect_cnt;

   int checks   = 0;
   int failures = 0;

   wb_commit_unit_if exwb ();

   wb_commit_unit #(.FLUSH_DEPTH(3), .CNT_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .exwb           (exwb.slave),
      .rf_we          (rf_we),
      .rf_waddr       (rf_waddr),
      .rf_wdata       (rf_wdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flushing       (flushing),
      .retired_cnt    (retired_cnt),
      .redirect_cnt   (redirect_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      exwb.wb_valid      = 1'b0;
      exwb.RegWrt        = 1'b0;
      exwb.MemToReg      = 1'b0;
      exwb.PCtoReg       = 1'b0;
      exwb.Branching     = 1'b0;
      exwb.BranchZero    = 1'b0;
      exwb.Jump          = 1'b0;
      exwb.JumpMem       = 1'b0;
      exwb.N             = 1'b0;
      exwb.Z             = 1'b0;
      exwb.ALUResult     = '0;
      exwb.DataMemOutput = '0;
      exwb.offset        = '0;
      exwb.pc_plus1      = '0;
      exwb.rd            = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_we"},   64'(rf_we), 64'd0);
      check({tag, "_wa"},   64'(rf_waddr), 64'd0);
      check({tag, "_wd"},   64'(rf_wdata), 64'd0);
      check({tag, "_rv"},   64'(redirect_valid), 64'd0);
      check({tag, "_rpc"},  64'(redirect_pc), 64'd0);
      check({tag, "_fl"},   64'(flushing), 64'd0);
      check({tag, "_ret"},  64'(retired_cnt), 64'd0);
      check({tag, "_rdc"},  64'(redirect_cnt), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      step();
      step();
      check_all_zero("reset");

      rst = 1'b0;
      step();
      check("idle_ret", 64'(retired_cnt), 64'd0);

      exwb.wb_valid = 1'b1; exwb.RegWrt = 1'b1; exwb.ALUResult = 32'h0000_00AA; exwb.rd = 6'd5;
      step();
      check("alu_we", 64'(rf_we), 64'd1);
      check("alu_wa", 64'(rf_waddr), 64'd5);
      check("alu_wd", 64'(rf_wdata), 64'hAA);
      check("alu_rv", 64'(redirect_valid), 64'd0);
      check("alu_ret", 64'(retired_cnt), 64'd1);

      clear_inputs();
      exwb.RegWrt = 1'b1; exwb.Jump = 1'b1; exwb.ALUResult = 32'h77;
      step();
      check("nonlive_we", 64'(rf_we), 64'd0);
      check("nonlive_rv", 64'(redirect_valid), 64'd0);
      check("nonlive_ret", 64'(retired_cnt), 64'd1);

      clear_inputs();
      exwb.wb_valid = 1'b1; exwb.RegWrt = 1'b1; exwb.PCtoReg = 1'b1; exwb.MemToReg = 1'b1;
      exwb.pc_plus1 = 32'h40; exwb.DataMemOutput = 32'h99; exwb.ALUResult = 32'h55; exwb.rd = 6'd7;
      step();
      check("prio_pc_wd", 64'(rf_wdata), 64'h40);
      check("prio_pc_wa", 64'(rf_waddr), 64'd7);
      exwb.PCtoReg = 1'b0;
      step();
      check("prio_mem_wd", 64'(rf_wdata), 64'h99);
      check("prio_ret", 64'(retired_cnt), 64'd3);

      clear_inputs();
      exwb.wb_valid = 1'b1; exwb.Branching = 1'b1; exwb.BranchZero = 1'b1; exwb.Z = 1'b1;
      exwb.offset = 32'h100;
      step();
      check("bz_rv", 64'(redirect_valid), 64'd1);
      check("bz_rpc", 64'(redirect_pc), 64'h100);
      check("bz_fl", 64'(flushing), 64'd1);
      check("bz_rdc", 64'(redirect_cnt), 64'd1);
      check("bz_ret", 64'(retired_cnt), 64'd4);

      for (int i = 0; i < 3; i++) begin
         clear_inputs();
         exwb.wb_valid = 1'b1; exwb.RegWrt = 1'b1; exwb.ALUResult = 32'h11; exwb.rd = 6'd3;
         exwb.Jump = (i == 0);
         step();
         check($sformatf("sq%0d_we", i), 64'(rf_we), 64'd0);
         check($sformatf("sq%0d_rv", i), 64'(redirect_valid), 64'd0);
         check($sformatf("sq%0d_fl", i), 64'(flushing), (i < 2) ? 64'd1 : 64'd0);
      end
      check("sq_ret", 64'(retired_cnt), 64'd4);
      check("sq_rdc", 64'(redirect_cnt), 64'd1);

      exwb.Jump = 1'b1;
      step();
      check("edge_we", 64'(rf_we), 64'd1);
      check("edge_wd", 64'(rf_wdata), 64'h11);
      check("edge_rv", 64'(redirect_valid), 64'd1);
      check("edge_rpc", 64'(redirect_pc), 64'h11);
      check("edge_rdc", 64'(redirect_cnt), 64'd2);
      check("edge_ret", 64'(retired_cnt), 64'd5);

      clear_inputs();
      step();
      check("pulse_rv", 64'(redirect_valid), 64'd0);
      step();
      step();
      check("drain1_fl", 64'(flushing), 64'd0);

      exwb.wb_valid = 1'b1; exwb.JumpMem = 1'b1; exwb.Jump = 1'b1; exwb.Branching = 1'b1;
      exwb.N = 1'b1; exwb.DataMemOutput = 32'h2000; exwb.ALUResult = 32'h3000; exwb.offset = 32'h10;
      step();
      check("jprio_rpc", 64'(redirect_pc), 64'h2000);
      check("jprio_rdc", 64'(redirect_cnt), 64'd3);
      check("jprio_ret", 64'(retired_cnt), 64'd6);
      clear_inputs();
      step();
      step();
      step();
      check("drain2_fl", 64'(flushing), 64'd0);

      exwb.wb_valid = 1'b1; exwb.Branching = 1'b1; exwb.BranchZero = 1'b0; exwb.N = 1'b0;
      exwb.Z = 1'b1; exwb.offset = 32'h80;
      step();
      check("nt_rv", 64'(redirect_valid), 64'd0);
      check("nt_fl", 64'(flushing), 64'd0);
      check("nt_ret", 64'(retired_cnt), 64'd7);
      check("nt_rdc", 64'(redirect_cnt), 64'd3);

      exwb.N = 1'b1; exwb.Z = 1'b0; exwb.offset = 32'h55;
      step();
      check("bn_rv", 64'(redirect_valid), 64'd1);
      check("bn_rpc", 64'(redirect_pc), 64'h55);
      check("bn_rdc", 64'(redirect_cnt), 64'd4);
      check("bn_ret", 64'(retired_cnt), 64'd8);

      clear_inputs();
      step();
      check("fl2_fl", 64'(flushing), 64'd1);
      rst = 1'b1;
      step();
      check_all_zero("rstfl");

      rst = 1'b0;
      exwb.wb_valid = 1'b1; exwb.RegWrt = 1'b1; exwb.ALUResult = 32'hDEAD_BEEF; exwb.rd = 6'd63;
      step();
      check("post_we", 64'(rf_we), 64'd1);
      check("post_wa", 64'(rf_waddr), 64'd63);
      check("post_wd", 64'(rf_wdata), 64'hDEAD_BEEF);
      check("post_fl", 64'(flushing), 64'd0);
      check("post_ret", 64'(retired_cnt), 64'd1);

      exwb.rd = 6'd0; exwb.ALUResult = 32'h1234;
      step();
      check("r0_we", 64'(rf_we), 64'd1);
      check("r0_wa", 64'(rf_waddr), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_commit_unit.md
# wb_commit_unit

Write-back and control-commit stage at the consumer end of the EX/WB pipeline register. Each cycle it takes the registered EX/WB bundle, selects the register-file write data, and resolves branches and jumps into a single PC redirect. After a redirect it squashes the younger in-flight instructions for a fixed number of cycles. It also keeps retired and redirect counters for the test bench and debug.

## Interface
Parameters:
- FLUSH_DEPTH, 3: number of cycles squashed after a redirect (1..15).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  reset, synchronous and active-high.
- wb_valid  in  1  EX/WB slot holds a real instruction.
- RegWrt, MemToReg, PCtoReg  in  1 each  write-back controls from EX/WB.
- Branching, BranchZero, Jump, JumpMem  in  1 each  control-transfer controls from EX/WB.
- N, Z  in  1 each  ALU flags from EX/WB.
- ALUResult, DataMemOutput, offset  in  32 each  EX/WB data.
- pc_plus1  in  32  PC+1 of this instruction.
- rd  in  6  destination register.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  6  register-file write address.
- rf_wdata  out  32  register-file write data.
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  32  redirect target.
- flushing  out  1  high while the squash window is active.
- retired_cnt, redirect_cnt  out  CNT_W each  performance counters.

## Operation
- An instruction is **live** when wb_valid=1 and flushing=0. A non-live slot produces no write, no redirect and no counter change.
- **Write data select** (priority order):
  - PCtoReg → pc_plus1
  - else MemToReg → DataMemOutput
  - else ALUResult
- **Register write:** rf_we = live & RegWrt, with rf_waddr = rd. All 64 addresses are writable, including 0.
- **Redirect decision** (priority order):
  - JumpMem → target DataMemOutput
  - else Jump → target ALUResult
  - else Branching & BranchZero & Z → target offset
  - else Branching & !BranchZero & N → target offset
  - else no redirect
- A not-taken branch retires normally. A redirecting instruction still performs its own register write, so jump-and-link works through PCtoReg.
- **States:**
  - RUN: on a live redirect, go to FLUSH and load squash_cnt = FLUSH_DEPTH.
  - FLUSH: squash_cnt decrements every cycle, independent of wb_valid. When squash_cnt reaches 1, go to RUN on the next cycle. flushing=1 in FLUSH.
- **Counters:**
  - retired_cnt increments on every live slot.
  - redirect_cnt increments on every live redirect.
  - Both wrap modulo 2^CNT_W.
- **Reset:** rst=1 forces every output to 0, sets state to RUN, and sets squash_cnt and both counters to 0. Reset in the middle of FLUSH aborts the window immediately.

## Timing
- All outputs are registered. Latency is 1 cycle: inputs sampled at edge k appear on the outputs after edge k.
- redirect_valid is high for exactly 1 cycle per live redirect.
- flushing rises in the same cycle as redirect_valid and stays high for exactly FLUSH_DEPTH cycles.
- Any redirect condition arriving during FLUSH is ignored, because that slot is squashed.
- A live redirect arriving on the cycle FLUSH ends (the first cycle back in RUN) is honoured.
- rf_we is 0 in every cycle where flushing=1, and in the cycle of reset release.

## Structure
- Shared CPU package holds:
  - the state enum (RUN, FLUSH)
  - the widths REG_ADDR_W=6 and DATA_W=32
- One sub-module, wb_redirect_sel: purely combinational target/taken priority logic, reusable by a future early-branch resolver.
- The muxes, FSM and counters stay in the top module.

## Test plan
- **ALU write:** live, RegWrt=1, ALUResult=0x0000_00AA, rd=5 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xAA; redirect_valid=0; retired_cnt=1.
- **Write-select priority:** PCtoReg=1, MemToReg=1, pc_plus1=0x40, DataMemOutput=0x99 → rf_wdata=0x40.
- **Taken branch-zero:** Branching=1, BranchZero=1, Z=1, offset=0x100 → redirect_valid pulse with redirect_pc=0x100, then flushing=1 for 3 cycles. Three back-to-back valid RegWrt slots during the window produce rf_we=0. The 4th slot writes. redirect_cnt=1.
- **Jump priority:** JumpMem=1, Jump=1, Branching=1, N=1, DataMemOutput=0x2000, ALUResult=0x3000, offset=0x10 → redirect_pc=0x2000.
- **Not-taken branch:** Branching=1, BranchZero=0, N=0 → no redirect, flushing stays 0, retired_cnt increments.
- **Reset during flush:** assert rst on the 2nd flush cycle → all outputs 0 next cycle. After release, a live RegWrt slot writes immediately (flushing=0).
